// File: rtl/fft_pkg.sv
// Shared FFT types: complex sample format, reorder bank states and the bit-reverse helper.
package fft_pkg;

   localparam int FFT_MIN_LOG2 = 2;
   localparam int BR_W         = 16;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } complex_t;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
   typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

   // Reverses the low 'width' bits of value; bits above width must already be zero.
   function automatic logic [BR_W-1:0] bit_reverse(input logic [BR_W-1:0] value,
                                                   input logic [4:0]      width);
      logic [BR_W-1:0] rev;
      for (int i = 0; i < BR_W; i++) rev[i] = value[BR_W-1-i];
      return rev >> (5'(BR_W) - width);
   endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port (1-cycle latency).
module reorder_bank_ram
   import fft_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  complex_t      wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output complex_t      rdata
);

   complex_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorderer using ping-pong banks in one RAM (bank index = address MSB).
// Define FFT_REORDER_SHIFT_EN to emit fftshifted order (N/2..N-1, 0..N/2-1).
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int MAX_FFT_SIZE = 1024,
   parameter int MAX_LOG2     = $clog2(MAX_FFT_SIZE)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [$clog2(MAX_LOG2+1)-1:0] cfg_log2n,
   input  complex_t                      din,
   input  logic                          din_valid,
   output logic                          din_ready,
   output complex_t                      dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic                          dout_last,
   output logic                          overflow
);

   localparam int LW = $clog2(MAX_LOG2+1);
   typedef logic [MAX_LOG2-1:0] addr_t;

   typedef struct packed {
      logic     last;
      logic     bank;
      complex_t data;
   } skid_t;

   function automatic addr_t size_mask(input logic [LW-1:0] l2);
      return {MAX_LOG2{1'b1}} >> (LW'(MAX_LOG2) - l2);
   endfunction

   bank_state_e     bank_state_q [2];
   bank_state_e     bank_state_d [2];
   logic [LW-1:0]   bank_log2_q  [2];
   addr_t           wr_cnt_q, rd_cnt_q;
   logic            wb_q, rb_q;
   rd_state_e       rd_state_q, rd_state_d;
   logic            overflow_q;
   logic            rd_valid_q, rd_last_q, rd_bank_q;
   skid_t           skid_q [2];
   logic [1:0]      skid_cnt_q;
   complex_t        ram_rdata;

   logic [LW-1:0]   cfg_clamped, wr_log2, rd_log2;
   logic            wr_first, wr_fire, wr_last;
   addr_t           wr_addr, rd_mask, rd_addr;
   logic            rd_last, rd_en, pop, space, claim, claim_bank, free_bank, free;

   always_comb begin
      cfg_clamped = cfg_log2n;
      if (cfg_log2n < LW'(FFT_MIN_LOG2))  cfg_clamped = LW'(FFT_MIN_LOG2);
      else if (cfg_log2n > LW'(MAX_LOG2)) cfg_clamped = LW'(MAX_LOG2);
   end

   // Write side: size comes from cfg on a frame's first sample, from the latched register after.
   assign din_ready = (bank_state_q[wb_q] == EMPTY) || (bank_state_q[wb_q] == FILLING);
   assign wr_first  = (bank_state_q[wb_q] == EMPTY);
   assign wr_fire   = din_valid & din_ready;
   assign wr_log2   = wr_first ? cfg_clamped : bank_log2_q[wb_q];
   assign wr_last   = (wr_cnt_q == size_mask(wr_log2));
   assign wr_addr   = addr_t'(bit_reverse(BR_W'(wr_cnt_q), 5'(wr_log2)));

   // Read side: a RAM read is issued only when the skid buffer can absorb it even if dout stalls.
   assign rd_log2    = bank_log2_q[rb_q];
   assign rd_mask    = size_mask(rd_log2);
   assign rd_last    = (rd_cnt_q == rd_mask);
   assign dout_valid = (skid_cnt_q != 2'd0);
   assign pop        = dout_valid & dout_ready;
   assign space      = ({1'b0, skid_cnt_q} + {2'b0, rd_valid_q}) < (3'd2 + {2'b0, pop});
   assign rd_en      = ((rd_state_q == RD_STREAM) || (bank_state_q[rb_q] == FULL)) && space;
   assign free       = pop & skid_q[0].last;
   assign free_bank  = skid_q[0].bank;

`ifdef FFT_REORDER_SHIFT_EN
   assign rd_addr = rd_cnt_q ^ (rd_mask ^ (rd_mask >> 1));
`else
   assign rd_addr = rd_cnt_q;
`endif

   always_comb begin
      rd_state_d = rd_state_q;
      claim      = 1'b0;
      claim_bank = rb_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (bank_state_q[rb_q] == FULL) begin
               rd_state_d = RD_STREAM;
               claim      = 1'b1;
            end
         end
         RD_STREAM: begin
            if (rd_en && rd_last) begin
               if (bank_state_q[~rb_q] == FULL) begin
                  claim      = 1'b1;
                  claim_bank = ~rb_q;
               end else begin
                  rd_state_d = RD_IDLE;
               end
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Write, claim and free always target banks in disjoint states, so at most one applies per bank.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_state_d[b] = bank_state_q[b];
         if (wr_fire && (wb_q == 1'(b)))      bank_state_d[b] = wr_last ? FULL : FILLING;
         if (claim && (claim_bank == 1'(b)))  bank_state_d[b] = DRAINING;
         if (free && (free_bank == 1'(b)))    bank_state_d[b] = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_state_q[0] <= EMPTY;
         bank_state_q[1] <= EMPTY;
         bank_log2_q[0]  <= LW'(FFT_MIN_LOG2);
         bank_log2_q[1]  <= LW'(FFT_MIN_LOG2);
         wr_cnt_q        <= '0;
         rd_cnt_q        <= '0;
         wb_q            <= 1'b0;
         rb_q            <= 1'b0;
         rd_state_q      <= RD_IDLE;
         overflow_q      <= 1'b0;
         rd_valid_q      <= 1'b0;
         rd_last_q       <= 1'b0;
         rd_bank_q       <= 1'b0;
      end else begin
         bank_state_q[0] <= bank_state_d[0];
         bank_state_q[1] <= bank_state_d[1];
         rd_state_q      <= rd_state_d;
         rd_valid_q      <= rd_en;
         rd_last_q       <= rd_last;
         rd_bank_q       <= rb_q;
         if (din_valid && !din_ready) overflow_q <= 1'b1;
         if (wr_fire) begin
            if (wr_first) bank_log2_q[wb_q] <= cfg_clamped;
            wr_cnt_q <= wr_last ? '0 : wr_cnt_q + addr_t'(1);
            if (wr_last) wb_q <= ~wb_q;
         end
         if (rd_en) begin
            rd_cnt_q <= rd_last ? '0 : rd_cnt_q + addr_t'(1);
            if (rd_last) rb_q <= ~rb_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
         skid_cnt_q <= '0;
      end else begin
         case ({rd_valid_q, pop})
            2'b10: begin
               if (skid_cnt_q == 2'd0) skid_q[0] <= '{rd_last_q, rd_bank_q, ram_rdata};
               else                    skid_q[1] <= '{rd_last_q, rd_bank_q, ram_rdata};
               skid_cnt_q <= skid_cnt_q + 2'd1;
            end
            2'b01: begin
               skid_q[0]  <= skid_q[1];
               skid_cnt_q <= skid_cnt_q - 2'd1;
            end
            2'b11: begin
               if (skid_cnt_q == 2'd1) begin
                  skid_q[0] <= '{rd_last_q, rd_bank_q, ram_rdata};
               end else begin
                  skid_q[0] <= skid_q[1];
                  skid_q[1] <= '{rd_last_q, rd_bank_q, ram_rdata};
               end
            end
            default: ;
         endcase
      end
   end

   assign dout      = skid_q[0].data;
   assign dout_last = dout_valid & skid_q[0].last;
   assign overflow  = overflow_q;

   reorder_bank_ram #(
      .DEPTH (2 * MAX_FFT_SIZE),
      .AW    (MAX_LOG2 + 1)
   ) u_ram (
      .clk   (clk),
      .we    (wr_fire),
      .waddr ({wb_q, wr_addr}),
      .wdata (din),
      .re    (rd_en),
      .raddr ({rb_q, rd_addr}),
      .rdata (ram_rdata)
   );

endmodule
